// File: rtl/cu_pkg.sv
// Shared definitions for the micro-coded control unit: opcodes, sequencer states, phase width.
package cu_pkg;
  localparam int PHASE_W = 2;
  localparam int OPC_W   = 4;

  localparam logic [OPC_W-1:0] CU_OP_HLT = 4'hF;
  localparam logic [OPC_W-1:0] CU_OP_SKF = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_WAIT_STEP = 2'd2,
    ST_HALTED    = 2'd3
  } seq_state_t;
endpackage

// File: rtl/cu_sequencer_if.sv
// Control/status bundle between the run controller and its host/datapath.
interface cu_sequencer_if #(parameter int ADDR_W = 5);
  logic              start;
  logic              abort;
  logic              step_mode;
  logic              step;
  logic [3:0]        opcode;
  logic              flag;
  logic [ADDR_W-1:0] addr;
  logic              T0, T1, T2, T3;
  logic              busy;
  logic              done;
  logic              halted;

  modport master (
    output start, abort, step_mode, step, opcode, flag,
    input  addr, T0, T1, T2, T3, busy, done, halted
  );

  modport slave (
    input  start, abort, step_mode, step, opcode, flag,
    output addr, T0, T1, T2, T3, busy, done, halted
  );
endinterface

// File: rtl/cu_phase_gen.sv
// Four-phase timing generator: 2-bit phase counter with clear/enable and one-hot strobe decode.
module cu_phase_gen
  import cu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic               run,
  output logic [PHASE_W-1:0] phase,
  output logic [3:0]         t
);
  logic [PHASE_W-1:0] phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (clr)     phase_d = '0;
    else if (en) phase_d = phase_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) phase_q <= '0;
    else     phase_q <= phase_d;
  end

  // run comes from the registered state, so strobes are purely flop-driven
  assign phase = phase_q;
  assign t     = run ? (4'b0001 << phase_q) : 4'b0000;
endmodule

// File: rtl/cu_sequencer.sv
// Run controller: sequences T0..T3 and the microprogram counter with start/done, halt,
// conditional skip, single-step and abort.
module cu_sequencer
  import cu_pkg::*;
#(
  parameter int               ADDR_W   = 5,
  parameter int               PROG_LEN = 32,
  parameter logic [OPC_W-1:0] OP_HLT   = CU_OP_HLT,
  parameter logic [OPC_W-1:0] OP_SKF   = CU_OP_SKF
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  cu_sequencer_if.slave  bus
);
  // last legal address, held one bit wider so addr+2 cannot wrap past it
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(PROG_LEN - 1);

  seq_state_t          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                done_q, done_d;
  logic                ph_clr, ph_en;
  logic [PHASE_W-1:0]  phase;
  logic [3:0]          t;
  logic [ADDR_W:0]     inc, sum;

  cu_phase_gen u_phase (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .clr   (ph_clr),
    .en    (ph_en),
    .run   (state_q == ST_RUN),
    .phase (phase),
    .t     (t)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    ph_clr  = 1'b0;
    ph_en   = 1'b0;
    inc     = (bus.opcode == OP_SKF && bus.flag) ? (ADDR_W+1)'(2) : (ADDR_W+1)'(1);
    sum     = {1'b0, addr_q} + inc;

    if (bus.abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      addr_d  = '0;
      ph_clr  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_HALTED: begin
          if (bus.start) begin
            state_d = ST_RUN;
            addr_d  = '0;
            ph_clr  = 1'b1;
          end
        end
        ST_RUN: begin
          ph_en = 1'b1;
          if (phase == PHASE_W'(3)) begin
            if (bus.opcode == OP_HLT) begin
              state_d = ST_HALTED;
              done_d  = 1'b1;
            end else if ({1'b0, addr_q} == LAST || sum > LAST) begin
              // sum > LAST is only reachable through a skip
              state_d = ST_IDLE;
              addr_d  = '0;
              done_d  = 1'b1;
            end else begin
              addr_d = sum[ADDR_W-1:0];
              if (bus.step_mode) state_d = ST_WAIT_STEP;
            end
          end
        end
        ST_WAIT_STEP: begin
          if (bus.step) begin
            state_d = ST_RUN;
            ph_clr  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
    end
  end

  assign bus.addr   = addr_q;
  assign bus.T0     = t[0];
  assign bus.T1     = t[1];
  assign bus.T2     = t[2];
  assign bus.T3     = t[3];
  assign bus.busy   = (state_q == ST_RUN) || (state_q == ST_WAIT_STEP);
  assign bus.done   = done_q;
  assign bus.halted = (state_q == ST_HALTED);
endmodule
